// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared types and constants for the ALU share arbiter
//
// Contents:
//   OP_*        4-bit ALU opcode encodings seen on req_opcode / alu_opcode
//   arb_state_e arbiter FSM states IDLE -> EXEC -> RESP
//   FLAG_*      bit positions of S/Z/C/V inside a 4-bit flag nibble
//   pack_flags  builds a {S,Z,C,V} nibble from the ALU's flag outputs

package alu_arb_pkg;

  // ALU opcodes. 0111 and 1100..1111 are undefined; the arbiter forwards
  // every opcode unchanged and always stores the flags the ALU returns.
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_CMP = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b0110;
  localparam logic [3:0] OP_SHL = 4'b1000;
  localparam logic [3:0] OP_SHR = 4'b1001;
  localparam logic [3:0] OP_ROL = 4'b1010;
  localparam logic [3:0] OP_SRA = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam int FLAG_S = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic [3:0] pack_flags(input logic s, input logic z,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_S] = s;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - request/response bundle between issue ports and arbiter
//
// Signals (index i = requester i, two requesters):
//   req_valid/req_ready   request handshake per requester
//   req_opcode/req_d      ALU opcode and shift amount per requester
//   req_a/req_b           operands per requester
//   req_lock              ask to keep the grant after this op
//   rsp_valid/rsp_ready   response handshake per requester
//   rsp_data              shared registered result, qualified by rsp_valid
//   rsp_flags             per-requester {S,Z,C,V} flag registers
// Modports: master = issue-port side, slave = arbiter side.

interface alu_share_arbiter_if #(
  parameter int W = 16
);

  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][3:0]   req_opcode;
  logic [1:0][3:0]   req_d;
  logic [1:0][W-1:0] req_a;
  logic [1:0][W-1:0] req_b;
  logic [1:0]        req_lock;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [W-1:0]      rsp_data;
  logic [1:0][3:0]   rsp_flags;

  modport master (
    output req_valid, req_opcode, req_d, req_a, req_b, req_lock, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_flags
  );

  modport slave (
    input  req_valid, req_opcode, req_d, req_a, req_b, req_lock, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_flags
  );

endinterface

// File: rtl/alu_arb_rr.sv
// rtl/alu_arb_rr.sv - two-way round-robin picker
//
// Ports:
//   req_valid  in  2  pending requests
//   rr_ptr     in  1  requester that has priority this round
//   lock_hold  in  1  only rr_ptr may be granted (the other one stalls)
//   winner     out 1  index of the selected requester
//   any        out 1  a grant is possible this cycle

module alu_arb_rr (
  input  logic [1:0] req_valid,
  input  logic       rr_ptr,
  input  logic       lock_hold,
  output logic       winner,
  output logic       any
);

  always_comb begin
    winner = rr_ptr;
    any    = req_valid[rr_ptr];
    // Fall over to the other requester only when the priority one is idle
    // and no lock is pinning the grant.
    if (!lock_hold && !req_valid[rr_ptr] && req_valid[~rr_ptr]) begin
      winner = ~rr_ptr;
      any    = 1'b1;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one 16-bit ALU between two requesters
//
// One operation at a time: IDLE accepts a request, EXEC drives the ALU from
// latched operands and captures its result, RESP presents the result until
// the owning requester takes it. Each requester keeps its own S/Z/C/V.
//
// Optional feature macro: ALU_ARB_LOCK_EN
//   defined   - a completed op with req_lock=1 keeps the grant on its issuer
//   undefined - req_lock is ignored, pure round-robin
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   bus (alu_share_arbiter_if)  request/response channels (slave side)
//   alu_opcode, alu_d           to ALU, held between operations
//   alu_a, alu_b                to ALU, held between operations
//   alu_out                     ALU result
//   alu_s, alu_z, alu_c, alu_v  ALU condition codes

module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int W    = 16,
  parameter int NREQ = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_share_arbiter_if.slave   bus,
  output logic [3:0]           alu_opcode,
  output logic [3:0]           alu_d,
  output logic [W-1:0]         alu_a,
  output logic [W-1:0]         alu_b,
  input  logic [W-1:0]         alu_out,
  input  logic                 alu_s,
  input  logic                 alu_z,
  input  logic                 alu_c,
  input  logic                 alu_v
);

  arb_state_e          state_q, state_d;
  logic                rr_ptr_q;
  logic                g_q;
  logic                winner;
  logic                any_valid;
  logic                lock_hold;
  logic                rr_next;
  logic [NREQ-1:0]     req_ready_d;
  logic [NREQ-1:0]     rsp_valid_d;
  logic [W-1:0]        rsp_data_q;
  logic [1:0][3:0]     flags_q;

  alu_arb_rr u_rr (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr_q),
    .lock_hold (lock_hold),
    .winner    (winner),
    .any       (any_valid)
  );

`ifdef ALU_ARB_LOCK_EN
  logic lock_q;
  logic lock_hold_q;

  // A locked op leaves the pointer on its issuer and pins the picker there;
  // the first unlocked op from that issuer hands priority to the other side.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q      <= 1'b0;
      lock_hold_q <= 1'b0;
    end else if (state_q == IDLE && any_valid) begin
      lock_q <= bus.req_lock[winner];
    end else if (state_q == RESP && bus.rsp_ready[g_q]) begin
      lock_hold_q <= lock_q;
    end
  end

  assign lock_hold = lock_hold_q;
  assign rr_next   = lock_q ? g_q : ~g_q;
`else
  logic unused_lock;
  assign unused_lock = &{1'b0, bus.req_lock};
  assign lock_hold   = 1'b0;
  assign rr_next     = ~g_q;
`endif

  always_comb begin
    state_d     = state_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    unique case (state_q)
      IDLE: begin
        // Ready follows valid combinationally, so any_valid already implies
        // the handshake completes at this edge.
        if (any_valid) begin
          req_ready_d[winner] = 1'b1;
          state_d             = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        rsp_valid_d[g_q] = 1'b1;
        if (bus.rsp_ready[g_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= 1'b0;
      g_q        <= 1'b0;
      alu_opcode <= '0;
      alu_d      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_data_q <= '0;
      flags_q    <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          // The alu_* registers double as the operand latch and keep their
          // value until the next accepted request.
          if (any_valid) begin
            g_q        <= winner;
            alu_opcode <= bus.req_opcode[winner];
            alu_d      <= bus.req_d[winner];
            alu_a      <= bus.req_a[winner];
            alu_b      <= bus.req_b[winner];
          end
        end
        EXEC: begin
          rsp_data_q   <= alu_out;
          flags_q[g_q] <= pack_flags(alu_s, alu_z, alu_c, alu_v);
        end
        RESP: begin
          if (bus.rsp_ready[g_q]) begin
            rr_ptr_q <= rr_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = req_ready_d;
  assign bus.rsp_valid = rsp_valid_d;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_flags = flags_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - randomized and directed bench for alu_share_arbiter

module tb_alu_share_arbiter;
  import alu_arb_pkg::*;

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  d;
    logic [15:0] a;
    logic [15:0] b;
    logic        lock;
  } op_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  alu_opcode, alu_d;
  logic [15:0] alu_a, alu_b, alu_out;
  logic        alu_s, alu_z, alu_c, alu_v;

  always #5 clk = ~clk;

  alu_share_arbiter_if #(.W(16)) bus ();

  alu_share_arbiter #(.W(16), .NREQ(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .alu_opcode (alu_opcode),
    .alu_d      (alu_d),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_out    (alu_out),
    .alu_s      (alu_s),
    .alu_z      (alu_z),
    .alu_c      (alu_c),
    .alu_v      (alu_v)
  );

  // Reference ALU: returns {result, S, Z, C, V}; also serves as the DUT's ALU.
  function automatic logic [19:0] alu_fn(input logic [3:0] op, input logic [3:0] d,
                                         input logic [15:0] a, input logic [15:0] b);
    logic [16:0] t;
    logic [15:0] r;
    logic        c, v;
    t = '0; r = a; c = 1'b0; v = 1'b0;
    case (op)
      OP_ADD: begin
        t = {1'b0, a} + {1'b0, b}; r = t[15:0]; c = t[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      OP_SUB, OP_CMP: begin
        t = {1'b0, a} - {1'b0, b}; r = t[15:0]; c = t[16];
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOT: r = ~a;
      OP_SHL: r = a << d;
      OP_SHR: r = a >> d;
      OP_ROL: r = {a[14:0], a[15]};
      OP_SRA: r = 16'($signed(a) >>> d);
      default: r = a;
    endcase
    return {r, r[15], (r == 16'h0000), c, v};
  endfunction

  assign {alu_out, alu_s, alu_z, alu_c, alu_v} = alu_fn(alu_opcode, alu_d, alu_a, alu_b);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Stimulus controls, applied at the next negedge by step().
  op_t rq [2][$];
  bit  rst_req    = 1'b0;
  bit  drop_valid = 1'b0;
  bit  rsp_rand   = 1'b0;
  bit  rand_fill  = 1'b0;
  int  stall_left = 0;

  // Transaction-level model: one outstanding op, result visible two cycles
  // after acceptance, priority alternates after each completed op.
  int          cyc = 0;
  bit          m_out = 1'b0;
  int          m_issue = 0;
  bit          m_g = 1'b0;
  op_t         m_op = '{4'h0, 4'h0, 16'h0, 16'h0, 1'b0};
  bit          m_rr = 1'b0;
  bit          m_hold = 1'b0;
  logic [3:0]  m_flags [2] = '{4'h0, 4'h0};
  logic [15:0] m_data = 16'h0;

  // Observations of the DUT for directed checks.
  int          obs_g[$];
  logic [15:0] obs_data[$];
  logic [3:0]  obs_flags[$];
  int          obs_lat[$];
  int          obs_start[$];
  int          hs_cyc = 0;
  bit          prev_rv = 1'b0;

  function automatic op_t rand_op();
    op_t o;
    o.op   = 4'($urandom_range(0, 15));
    o.d    = 4'($urandom_range(0, 15));
    o.a    = 16'($urandom);
    o.b    = 16'($urandom);
    o.lock = ($urandom_range(0, 3) == 0);
    return o;
  endfunction

  function automatic op_t mk(input logic [3:0] op, input logic [15:0] a,
                             input logic [15:0] b, input logic lock);
    op_t o;
    o.op = op; o.d = 4'h0; o.a = a; o.b = b; o.lock = lock;
    return o;
  endfunction

  task automatic clear_obs();
    obs_g.delete(); obs_data.delete(); obs_flags.delete();
    obs_lat.delete(); obs_start.delete();
  endtask

  task automatic step();
    logic [1:0]  vld, exp_rdy, exp_rv;
    logic [19:0] res;
    bit          has;
    bit          gi;
    @(negedge clk);
    reset = rst_req;
    for (int i = 0; i < 2; i++) begin
      if (rand_fill && rq[i].size() == 0 && $urandom_range(0, 2) != 0)
        rq[i].push_back(rand_op());
      vld[i] = !drop_valid && (rq[i].size() > 0);
      bus.req_valid[i] = vld[i];
      if (rq[i].size() > 0) begin
        bus.req_opcode[i] = rq[i][0].op;
        bus.req_d[i]      = rq[i][0].d;
        bus.req_a[i]      = rq[i][0].a;
        bus.req_b[i]      = rq[i][0].b;
        bus.req_lock[i]   = rq[i][0].lock;
      end
    end
    if (rsp_rand)            bus.rsp_ready = 2'($urandom_range(0, 3));
    else if (stall_left > 0) bus.rsp_ready = 2'b00;
    else                     bus.rsp_ready = 2'b11;
    #1;

    has = 1'b0; gi = m_rr;
    if (!m_out) begin
      if (m_hold)          begin has = vld[m_rr];  gi = m_rr;  end
      else if (vld[m_rr])  begin has = 1'b1;       gi = m_rr;  end
      else if (vld[!m_rr]) begin has = 1'b1;       gi = !m_rr; end
    end
    exp_rdy = has ? (2'b01 << gi) : 2'b00;
    exp_rv  = (m_out && cyc >= m_issue + 2) ? (2'b01 << m_g) : 2'b00;

    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
    chk("rsp_data",  32'(bus.rsp_data),  32'(m_data));
    chk("flags0",    32'(bus.rsp_flags[0]), 32'(m_flags[0]));
    chk("flags1",    32'(bus.rsp_flags[1]), 32'(m_flags[1]));
    chk("alu_op_d",  32'({alu_opcode, alu_d}), 32'({m_op.op, m_op.d}));
    chk("alu_a",     32'(alu_a), 32'(m_op.a));
    chk("alu_b",     32'(alu_b), 32'(m_op.b));

    for (int i = 0; i < 2; i++) begin
      if (bus.req_valid[i] && bus.req_ready[i]) begin
        obs_g.push_back(i);
        hs_cyc = cyc;
      end
    end
    if ((|bus.rsp_valid) && !prev_rv) begin
      obs_data.push_back(bus.rsp_data);
      obs_flags.push_back(bus.rsp_valid[1] ? bus.rsp_flags[1] : bus.rsp_flags[0]);
      obs_lat.push_back(cyc - hs_cyc);
      obs_start.push_back(cyc);
    end
    prev_rv = |bus.rsp_valid;

    if (reset) begin
      m_out = 1'b0; m_rr = 1'b0; m_hold = 1'b0;
      m_flags = '{4'h0, 4'h0}; m_data = 16'h0;
      m_op = '{4'h0, 4'h0, 16'h0, 16'h0, 1'b0};
      stall_left = 0;
    end else begin
      if (m_out && cyc >= m_issue + 2) begin
        if (stall_left > 0) begin
          stall_left--;
        end else if (bus.rsp_ready[m_g]) begin
          m_out = 1'b0;
`ifdef ALU_ARB_LOCK_EN
          if (m_op.lock) begin m_hold = 1'b1; m_rr = m_g;  end
          else           begin m_hold = 1'b0; m_rr = !m_g; end
`else
          m_rr = !m_g;
`endif
        end
      end else if (has) begin
        m_out   = 1'b1;
        m_issue = cyc;
        m_g     = gi;
        m_op    = rq[gi].pop_front();
      end
      if (m_out && cyc + 1 == m_issue + 2) begin
        res = alu_fn(m_op.op, m_op.d, m_op.a, m_op.b);
        m_data = res[19:4];
        m_flags[m_g] = res[3:0];
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    rst_req = 1'b1; drop_valid = 1'b1;
    step();
    rst_req = 1'b0; drop_valid = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    bus.req_valid  = '0;
    bus.req_opcode = '0;
    bus.req_d      = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_lock   = '0;
    bus.rsp_ready  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_data",  32'(bus.rsp_data),  32'h0);
    chk("rst_flags",     32'(bus.rsp_flags), 32'h0);
    chk("rst_alu",       32'({alu_opcode, alu_d, alu_a}), 32'h0);

    // Single ADD from requester 0.
    clear_obs();
    rq[0].push_back(mk(OP_ADD, 16'h0003, 16'h0004, 1'b0));
    run(6);
    chk("t1_count", 32'(obs_data.size()), 32'd1);
    if (obs_data.size() >= 1) begin
      chk("t1_grant", 32'(obs_g[0]), 32'd0);
      chk("t1_data",  32'(obs_data[0]), 32'h0007);
      chk("t1_flags", 32'(obs_flags[0]), 32'h0);
      chk("t1_lat",   32'(obs_lat[0]), 32'd2);
    end

    // Continuous contention: strict alternation, 3 cycles per op.
    do_reset();
    clear_obs();
    for (int k = 0; k < 4; k++) begin
      rq[0].push_back(mk(OP_ADD, 16'($urandom), 16'($urandom), 1'b0));
      rq[1].push_back(mk(OP_SUB, 16'($urandom), 16'($urandom), 1'b0));
    end
    run(28);
    chk("t2_count", 32'(obs_g.size()), 32'd8);
    if (obs_g.size() >= 4) begin
      for (int k = 0; k < 4; k++) chk("t2_order", 32'(obs_g[k]), 32'(k % 2));
    end
    if (obs_start.size() >= 4) begin
      for (int k = 0; k < 3; k++) chk("t2_spacing", 32'(obs_start[k+1] - obs_start[k]), 32'd3);
    end

    // Overflow then zero result on requester 1.
    clear_obs();
    rq[1].push_back(mk(OP_ADD, 16'h7FFF, 16'h0001, 1'b0));
    rq[1].push_back(mk(OP_XOR, 16'h00FF, 16'h00FF, 1'b0));
    run(10);
    chk("t3_count", 32'(obs_data.size()), 32'd2);
    if (obs_data.size() >= 2) begin
      chk("t3_add_data",  32'(obs_data[0]),  32'h8000);
      chk("t3_add_flags", 32'(obs_flags[0]), 32'b1001);
      chk("t3_xor_data",  32'(obs_data[1]),  32'h0000);
      chk("t3_xor_flags", 32'(obs_flags[1]), 32'b0100);
    end

    // Response stall of 5 cycles with the other requester waiting.
    clear_obs();
    stall_left = 5;
    rq[0].push_back(mk(OP_OR, 16'h1234, 16'h4321, 1'b0));
    rq[1].push_back(mk(OP_AND, 16'hF0F0, 16'h0FF0, 1'b0));
    run(18);
    chk("t4_count", 32'(obs_start.size()), 32'd2);
    if (obs_start.size() >= 2) begin
      chk("t4_first", 32'(obs_g[0]), 32'd0);
      chk("t4_gap",   32'(obs_start[1] - obs_start[0]), 32'd8);
    end

    // Reset while an op is in EXEC.
    rq[0].push_back(mk(OP_ADD, 16'h8000, 16'h8000, 1'b0));
    step();
    rst_req = 1'b1; drop_valid = 1'b1;
    step();
    rst_req = 1'b0; drop_valid = 1'b0;
    clear_obs();
    run(3);
    chk("t5_flags",   32'(bus.rsp_flags), 32'h0);
    chk("t5_no_rsp",  32'(obs_data.size()), 32'd0);
    rq[1].push_back(mk(OP_SUB, 16'h0005, 16'h0009, 1'b0));
    rq[0].push_back(mk(OP_ADD, 16'h0001, 16'h0001, 1'b0));
    run(8);
    chk("t5_count", 32'(obs_g.size()), 32'd2);
    if (obs_g.size() >= 1) chk("t5_first", 32'(obs_g[0]), 32'd0);

    // Lock sequence: req0 lock=1,1,0 with req1 always waiting.
    do_reset();
    clear_obs();
    rq[0].push_back(mk(OP_ADD, 16'h0010, 16'h0001, 1'b1));
    rq[0].push_back(mk(OP_ADD, 16'h0020, 16'h0002, 1'b1));
    rq[0].push_back(mk(OP_ADD, 16'h0030, 16'h0003, 1'b0));
    rq[1].push_back(mk(OP_XOR, 16'hAAAA, 16'h5555, 1'b0));
    rq[1].push_back(mk(OP_XOR, 16'h1111, 16'h1111, 1'b0));
    run(20);
    chk("t6_count", 32'(obs_g.size()), 32'd5);
    if (obs_g.size() >= 4) begin
`ifdef ALU_ARB_LOCK_EN
      chk("t6_order0", 32'(obs_g[0]), 32'd0);
      chk("t6_order1", 32'(obs_g[1]), 32'd0);
      chk("t6_order2", 32'(obs_g[2]), 32'd0);
      chk("t6_order3", 32'(obs_g[3]), 32'd1);
`else
      chk("t6_order0", 32'(obs_g[0]), 32'd0);
      chk("t6_order1", 32'(obs_g[1]), 32'd1);
      chk("t6_order2", 32'(obs_g[2]), 32'd0);
      chk("t6_order3", 32'(obs_g[3]), 32'd1);
`endif
    end

    // Random traffic with random response back-pressure, then drain.
    do_reset();
    rsp_rand = 1'b1; rand_fill = 1'b1;
    run(600);
    rsp_rand = 1'b0; rand_fill = 1'b0;
    run(40);
    chk("t7_drained", 32'(rq[0].size() + rq[1].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
